// File: rtl/raw10_unpack_if.sv
// Byte-in / pixel-out bundle for the CSI-2 RAW10 unpacker.
// The slave modport is the unpacker's view; the master modport is the source/sink side.
interface raw10_unpack_if;
  logic       LineStart;
  logic [7:0] ByteData;
  logic       ByteValid;
  logic       ByteReady;
  logic       FifoFull;
  logic [9:0] PixData;
  logic       PixWrEn;
  logic       LineDone;
  logic       Misalign;

  modport slave (
    input  LineStart, ByteData, ByteValid, FifoFull,
    output ByteReady, PixData, PixWrEn, LineDone, Misalign
  );

  modport master (
    output LineStart, ByteData, ByteValid, FifoFull,
    input  ByteReady, PixData, PixWrEn, LineDone, Misalign
  );
endinterface

// File: rtl/raw10_unpack.sv
// CSI-2 RAW10 unpacker: 5 payload bytes -> 4 ten-bit pixels into a FIFO, with line counting.
// Define RAW10_UNPACK_MISALIGN_EN to enable the sticky Misalign detector (tied to 0 otherwise).
module raw10_unpack #(
  parameter int LINE_PIXELS = 1920
) (
  input logic           Clock,
  input logic           Reset_n,
  raw10_unpack_if.slave bus
);
  localparam logic [15:0] LAST_PIX = 16'(LINE_PIXELS - 1);

  logic        run_q;
  logic [2:0]  phase_q, phase_d;
  logic [31:0] asm_q, asm_d;
  logic [39:0] emit_q, emit_d;
  logic        emit_vld_q, emit_vld_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        byte_rdy, accept, load, wr;
  logic [9:0]  pix;

  // B4 may only be taken once the emit register is free or freeing on this edge
  assign byte_rdy = run_q && ((phase_q != 3'd4) || !emit_vld_q ||
                              (idx_q == 2'd3 && !bus.FifoFull));
  assign accept   = bus.ByteValid && byte_rdy;
  assign load     = accept && (phase_q == 3'd4) && !bus.LineStart;
  assign wr       = emit_vld_q && !bus.FifoFull;

  always_comb begin
    pix = '0;
    case (idx_q)
      2'd0: pix = {emit_q[7:0],   emit_q[33:32]};
      2'd1: pix = {emit_q[15:8],  emit_q[35:34]};
      2'd2: pix = {emit_q[23:16], emit_q[37:36]};
      2'd3: pix = {emit_q[31:24], emit_q[39:38]};
      default: pix = '0;
    endcase
  end

  always_comb begin
    phase_d    = phase_q;
    asm_d      = asm_q;
    emit_d     = emit_q;
    emit_vld_d = emit_vld_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;

    // A byte arriving with LineStart becomes B0 of the new line
    if (bus.LineStart) begin
      phase_d = accept ? 3'd1 : 3'd0;
      asm_d   = accept ? {24'd0, bus.ByteData} : '0;
    end else if (accept) begin
      phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
      case (phase_q)
        3'd0:    asm_d[7:0]   = bus.ByteData;
        3'd1:    asm_d[15:8]  = bus.ByteData;
        3'd2:    asm_d[23:16] = bus.ByteData;
        3'd3:    asm_d[31:24] = bus.ByteData;
        default: asm_d        = asm_q;
      endcase
    end

    if (load) begin
      emit_d     = {bus.ByteData, asm_q};
      emit_vld_d = 1'b1;
      idx_d      = 2'd0;
    end else if (wr) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) emit_vld_d = 1'b0;
    end

    if (bus.LineStart)   cnt_d = '0;
    else if (wr)         cnt_d = (cnt_q == LAST_PIX) ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      run_q      <= 1'b0;
      phase_q    <= 3'd0;
      emit_vld_q <= 1'b0;
      idx_q      <= 2'd0;
      cnt_q      <= 16'd0;
    end else begin
      run_q      <= 1'b1;
      phase_q    <= phase_d;
      emit_vld_q <= emit_vld_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  // Pixel payload needs no reset: it is only observed while emit_vld_q is set
  always_ff @(posedge Clock) begin
    asm_q  <= asm_d;
    emit_q <= emit_d;
  end

  assign bus.ByteReady = byte_rdy;
  assign bus.PixWrEn   = wr;
  assign bus.PixData   = emit_vld_q ? pix : 10'd0;
  assign bus.LineDone  = wr && (cnt_q == LAST_PIX) && !bus.LineStart;

`ifdef RAW10_UNPACK_MISALIGN_EN
  logic mis_q;
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                              mis_q <= 1'b0;
    else if (bus.LineStart && phase_q != 3'd0) mis_q <= 1'b1;
  end
  assign bus.Misalign = mis_q;
`else
  assign bus.Misalign = 1'b0;
`endif
endmodule

// File: tb/tb_raw10_unpack.sv
// Scoreboard bench for raw10_unpack (LINE_PIXELS = 8): stimulus pushes expected pixels,
// a negedge monitor pops and compares on every FIFO write.
module tb_raw10_unpack;
  logic Clock = 1'b0;
  logic Reset_n = 1'b0;

  raw10_unpack_if bus();
  raw10_unpack #(.LINE_PIXELS(8)) dut (.Clock(Clock), .Reset_n(Reset_n), .bus(bus));

  always #5 Clock = ~Clock;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          exp_lc = 0;
  int          stalls = 0;
  logic [10:0] expq[$];
  int          wr_times[$];
  logic [10:0] mon_e;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every FIFO write must match the head of the scoreboard
  always @(negedge Clock) begin
    if (Reset_n) begin
      if (bus.PixWrEn) begin
        wr_times.push_back(cyc);
        check("no_write_when_full", 32'(bus.FifoFull), 32'd0);
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got pixel %0h expected no write", bus.PixData);
        end else begin
          mon_e = expq.pop_front();
          check("pix_data", 32'(bus.PixData), 32'(mon_e[9:0]));
          check("line_done", 32'(bus.LineDone), 32'(mon_e[10]));
        end
      end else if (bus.LineDone) begin
        tests++; fails++;
        $display("FAIL line_done_without_write: got 1 expected 0");
      end
    end
  end

  task automatic push_pix(input logic [9:0] p);
    logic ld;
    ld = (exp_lc == 7);
    expq.push_back({ld, p});
    exp_lc = ld ? 0 : exp_lc + 1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.ByteData  = b;
    bus.ByteValid = 1'b1;
    @(negedge Clock);
    while (!bus.ByteReady && n < 50) begin
      n++;
      @(negedge Clock);
    end
    stalls += n;
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL byte_accept_timeout: got no ByteReady expected ready within 50 cycles");
    end
    @(posedge Clock); #1;
    bus.ByteValid = 1'b0;
  endtask

  task automatic send_group(input logic [7:0] b0, b1, b2, b3, b4,
                            input logic [9:0] p0, p1, p2, p3);
    send(b0); send(b1); send(b2); send(b3); send(b4);
    push_pix(p0); push_pix(p1); push_pix(p2); push_pix(p3);
  endtask

  task automatic line_start();
    bus.LineStart = 1'b1;
    exp_lc = 0;
    @(posedge Clock); #1;
    bus.LineStart = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((expq.size() != 0 || bus.PixWrEn) && n < 100) begin
      n++;
      @(posedge Clock); #1;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
    end
    repeat (2) @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int w0;
  initial begin
    bus.LineStart = 1'b0;
    bus.ByteData  = 8'h00;
    bus.ByteValid = 1'b0;
    bus.FifoFull  = 1'b0;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("rst_ready",    32'(bus.ByteReady), 32'd0);
    check("rst_wren",     32'(bus.PixWrEn),   32'd0);
    check("rst_pixdata",  32'(bus.PixData),   32'd0);
    check("rst_linedone", 32'(bus.LineDone),  32'd0);
    check("rst_misalign", 32'(bus.Misalign),  32'd0);
    Reset_n = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(bus.ByteReady), 32'd0);
    @(posedge Clock); #1;
    check("ready_after_first_edge", 32'(bus.ByteReady), 32'd1);

    // Two back-to-back groups: 10 bytes, 8 writes, LineDone on the 8th
    line_start();
    stalls = 0;
    w0 = wr_times.size();
    send_group(8'hAA, 8'h55, 8'hFF, 8'h00, 8'hE4, 10'h2A8, 10'h155, 10'h3FE, 10'h003);
    send_group(8'h01, 8'h02, 8'h03, 8'h04, 8'h1B, 10'h007, 10'h00A, 10'h00D, 10'h010);
    check("burst_no_stall", 32'(stalls), 32'd0);
    wait_idle();
    check("burst_write_count", 32'(wr_times.size() - w0), 32'd8);
    check("group_consecutive", 32'(wr_times[w0+3] - wr_times[w0]), 32'd3);
    check("misalign_clean_line", 32'(bus.Misalign), 32'd0);

    // FifoFull held for 3 cycles while P1 is pending
    send_group(8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 10'h040, 10'h080, 10'h0C0, 10'h100);
    @(posedge Clock); #1;
    bus.FifoFull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("full_hold_wren", 32'(bus.PixWrEn), 32'd0);
      check("full_hold_data", 32'(bus.PixData), 32'h080);
      @(posedge Clock); #1;
    end
    bus.FifoFull = 1'b0;
    // Counter wrapped after the first line, so LineDone lands on 0x203
    send_group(8'h50, 8'h60, 8'h70, 8'h80, 8'hFF, 10'h143, 10'h183, 10'h1C3, 10'h203);
    wait_idle();

    // LineStart after 3 bytes drops the partial group
    send(8'h11); send(8'h22); send(8'h33);
    line_start();
`ifdef RAW10_UNPACK_MISALIGN_EN
    check("misalign_set", 32'(bus.Misalign), 32'd1);
`else
    check("misalign_tied_low", 32'(bus.Misalign), 32'd0);
`endif
    send_group(8'h12, 8'h34, 8'h56, 8'h78, 8'h9C, 10'h048, 10'h0D3, 10'h159, 10'h1E2);
    wait_idle();

    // LineStart coincident with the first byte
    bus.LineStart = 1'b1;
    exp_lc = 0;
    send(8'hA0);
    bus.LineStart = 1'b0;
    send(8'hB0); send(8'hC0); send(8'hD0); send(8'h00);
    push_pix(10'h280); push_pix(10'h2C0); push_pix(10'h300); push_pix(10'h340);
    wait_idle();

    // Reset asserted while P2 is being presented
    send_group(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 10'h004, 10'h008, 10'h00C, 10'h010);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    check("p2_presented_wren", 32'(bus.PixWrEn), 32'd1);
    check("p2_presented_data", 32'(bus.PixData), 32'h00C);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_wren",    32'(bus.PixWrEn),   32'd0);
    check("mid_rst_pixdata", 32'(bus.PixData),   32'd0);
    check("mid_rst_ready",   32'(bus.ByteReady), 32'd0);
    void'(expq.pop_back());
    void'(expq.pop_back());
    exp_lc = 0;
    repeat (2) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    #1;
    check("rel_ready_before_edge", 32'(bus.ByteReady), 32'd0);
    @(posedge Clock); #1;
    check("rel_ready_after_edge", 32'(bus.ByteReady), 32'd1);
    check("rel_misalign_cleared", 32'(bus.Misalign), 32'd0);
    repeat (5) @(posedge Clock);
    #1;
    check("scoreboard_empty", 32'(expq.size()), 32'd0);
    check("total_writes", 32'(wr_times.size()), 32'd26);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/raw10_unpack.md
RAW10_UNPACK -- requirements
Module: raw10_unpack

Interface
REQ-001 SHALL have parameter LINE_PIXELS, default 1920, meaning pixels per line; must be a nonzero multiple of 4 and no greater than 65535.
REQ-002 SHALL have port Clock  input  1  single clock for all logic.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port LineStart  input  1  single-cycle pulse marking the start of a line's payload.
REQ-005 SHALL have port ByteData  input  8  CSI-2 RAW10 payload byte.
REQ-006 SHALL have port ByteValid  input  1  ByteData is valid this cycle.
REQ-007 SHALL have port ByteReady  output  1  byte is accepted on a cycle where ByteValid and ByteReady are both 1.
REQ-008 SHALL have port FifoFull  input  1  Full flag of the downstream 10-bit image FIFO.
REQ-009 SHALL have port PixData  output  10  unpacked pixel, driven to FIFO Data.
REQ-010 SHALL have port PixWrEn  output  1  FIFO write enable.
REQ-011 SHALL have port LineDone  output  1  pulse coincident with the write of the last pixel of a line.
REQ-012 SHALL have port Misalign  output  1  sticky error flag.

Function
REQ-013 SHALL assemble 5 accepted bytes B0..B4 into 4 pixels: Pn = {Bn, B4[2n+1:2n]} for n = 0..3.
REQ-014 SHALL keep a byte phase counter 0..4 and a 40-bit assembly register; each accepted byte writes slot [phase], then phase increments, wrapping from 4 to 0.
REQ-015 SHALL, on acceptance of B4, transfer the group to a separate emit register, set emit-valid, and clear the emit index to 0.
REQ-016 SHALL drive ByteReady = 1 when phase < 4, or when phase = 4 and (emit register empty, or emit index = 3 with FifoFull = 0).
REQ-017 SHALL drive PixWrEn combinationally as emit-valid AND NOT FifoFull, and PixData combinationally as P[emit index]; no write ever occurs while FifoFull = 1.
REQ-018 SHALL advance the emit index on each write and clear emit-valid after the write of P3, unless a new group is loaded on the same edge.
REQ-019 SHALL sustain 1 byte per cycle with FifoFull = 0 and no ByteReady stall.
REQ-020 SHALL have latency as follows: B4 accepted at edge k gives P0 written in the cycle after k and P3 three cycles later, absent FifoFull.
REQ-021 SHALL keep a 16-bit pixel counter incremented per write; LineDone = PixWrEn AND (count = LINE_PIXELS-1), after which the counter wraps to 0.
REQ-022 SHALL, on LineStart, clear phase, the assembly register and the pixel counter, and discard any partial group; the emit register is not flushed and its remaining pixels are still written.
REQ-023 SHALL, when LineStart and an accepted byte coincide, apply the clear first and store the byte as B0 of the new line (phase becomes 1).
REQ-024 SHALL set Misalign when LineStart arrives with phase != 0; Misalign clears only on reset.
REQ-025 SHALL, when a pixel write and LineStart coincide, clear the counter with priority and assert no LineDone.

Reset
REQ-026 SHALL, while Reset_n = 0, hold phase 0, emit register empty, counter 0, Misalign 0, PixWrEn 0, PixData 0, LineDone 0 and ByteReady 0.
REQ-027 SHALL raise ByteReady on the first clock edge after Reset_n deasserts, using a registered run flag.
REQ-028 SHALL, on reset mid-group, discard the partial group and the emit register without issuing any further writes.

Configuration
REQ-029 SHALL, with macro RAW10_UNPACK_MISALIGN_EN defined, implement the Misalign detection of REQ-024.
REQ-030 SHALL, without RAW10_UNPACK_MISALIGN_EN, tie Misalign to constant 0 and leave all other behaviour unchanged.

Verification
REQ-031 SHALL cover: bytes AA,55,FF,00,E4 -> writes 2A8,155,3FE,003 on four consecutive cycles.
REQ-032 SHALL cover: 10 back-to-back bytes with FifoFull = 0 -> ByteReady never drops and 8 writes occur.
REQ-033 SHALL cover: FifoFull held high 3 cycles during P1 -> P1 is held, no write occurs while full, and no pixel is lost or duplicated.
REQ-034 SHALL cover: LINE_PIXELS = 8 with 10 bytes -> LineDone pulses with the 8th write and the counter returns to 0.
REQ-035 SHALL cover: LineStart after 3 bytes -> partial group dropped, Misalign = 1 (0 when the macro is undefined), and the next 5 bytes yield correct pixels.
REQ-036 SHALL cover: Reset_n low during P2 emission -> PixWrEn = 0 immediately and ByteReady = 1 one edge after release.
